// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and
// the IF/ID pipeline register, with boot/interrupt vector loads, stall and flush.
module fetch_stage #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] BOOT_VEC_ADDR = 8'h00,
  parameter logic [DATA_WIDTH-1:0] IRQ_VEC_ADDR  = 8'h01,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR     = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  irq,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus1,
  output logic                  if_id_valid,
  output logic                  irq_ack,
  output logic [DATA_WIDTH-1:0] irq_ret_pc
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    IRQ_VEC = 2'd2
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [DATA_WIDTH-1:0] pc_plus1_reg;
  logic                  valid_reg;
  logic                  irq_ack_reg;
  logic [DATA_WIDTH-1:0] irq_ret_pc_reg;
  logic [DATA_WIDTH-1:0] pc_inc;

  // Wraps modulo 2^DATA_WIDTH with no carry out.
  assign pc_inc = pc_reg + DATA_WIDTH'(1);

  always_comb begin
    imem_addr = pc_reg;
    case (state_reg)
      BOOT:    imem_addr = BOOT_VEC_ADDR;
      IRQ_VEC: imem_addr = IRQ_VEC_ADDR;
      default: imem_addr = pc_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= BOOT;
      pc_reg         <= '0;
      instr_reg      <= NOP_INSTR;
      pc_plus1_reg   <= '0;
      valid_reg      <= 1'b0;
      irq_ack_reg    <= 1'b0;
      irq_ret_pc_reg <= '0;
    end else begin
      case (state_reg)
        BOOT: begin
          pc_reg      <= imem_data;
          instr_reg   <= NOP_INSTR;
          valid_reg   <= 1'b0;
          irq_ack_reg <= 1'b0;
          state_reg   <= RUN;
        end

        RUN: begin
          irq_ack_reg <= 1'b0;
          if (flush) begin
            pc_reg    <= branch_target;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
          end else if (stall) begin
            pc_reg    <= pc_reg;
          end else if (irq) begin
            // PC holds: the instruction at PC has not entered IF/ID yet, so it is the return point.
            irq_ret_pc_reg <= pc_reg;
            instr_reg      <= NOP_INSTR;
            valid_reg      <= 1'b0;
            irq_ack_reg    <= 1'b1;
            state_reg      <= IRQ_VEC;
          end else begin
            instr_reg    <= imem_data;
            pc_plus1_reg <= pc_inc;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_inc;
          end
        end

        IRQ_VEC: begin
          pc_reg      <= imem_data;
          instr_reg   <= NOP_INSTR;
          valid_reg   <= 1'b0;
          irq_ack_reg <= 1'b0;
          state_reg   <= RUN;
          // An older branch resolving now means the handler must return to its target.
          if (flush) begin
            irq_ret_pc_reg <= branch_target;
          end
        end

        default: begin
          state_reg   <= BOOT;
          irq_ack_reg <= 1'b0;
        end
      endcase
    end
  end

  assign if_id_instr    = instr_reg;
  assign if_id_pc_plus1 = pc_plus1_reg;
  assign if_id_valid    = valid_reg;
  assign irq_ack        = irq_ack_reg;
  assign irq_ret_pc     = irq_ret_pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by random stall/flush/irq
// traffic, all compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [7:0] branch_target;
  logic       irq;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc_plus1;
  logic       if_id_valid;
  logic       irq_ack;
  logic [7:0] irq_ret_pc;

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase 0 = boot cycle, 1 = running, 2 = interrupt vector cycle.
  int m_phase;
  int m_pc;
  int m_instr;
  int m_pcp1;
  int m_valid;
  int m_ret;

  localparam int NOP = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_target  (branch_target),
    .irq            (irq),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .irq_ack        (irq_ack),
    .irq_ret_pc     (irq_ret_pc)
  );

  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr();
    if (m_phase == 0) return 0;
    if (m_phase == 2) return 1;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_instr = NOP; m_pcp1 = 0; m_valid = 0; m_ret = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, int'(imem_addr), exp_addr());
    chk({tag, ".instr"},     int'(if_id_instr), m_instr);
    chk({tag, ".pc_plus1"},  int'(if_id_pc_plus1), m_pcp1);
    chk({tag, ".valid"},     int'(if_id_valid), m_valid);
    chk({tag, ".irq_ack"},   int'(irq_ack), (m_phase == 2) ? 1 : 0);
    chk({tag, ".ret_pc"},    int'(irq_ret_pc), m_ret);
  endtask

  // Advance the model by one clock edge using the inputs held during that cycle.
  task automatic model_edge(input int s, input int f, input int bt, input int i);
    case (m_phase)
      0: begin
        m_pc = int'(mem[0]); m_instr = NOP; m_valid = 0; m_phase = 1;
      end
      2: begin
        m_pc = int'(mem[1]); m_instr = NOP; m_valid = 0; m_phase = 1;
        if (f != 0) m_ret = bt;
      end
      default: begin
        if (f != 0) begin
          m_pc = bt; m_instr = NOP; m_valid = 0;
        end else if (s != 0) begin
          m_pc = m_pc;
        end else if (i != 0) begin
          m_ret = m_pc; m_instr = NOP; m_valid = 0; m_phase = 2;
        end else begin
          m_instr = int'(mem[m_pc]);
          m_pcp1  = (m_pc + 1) % 256;
          m_valid = 1;
          m_pc    = (m_pc + 1) % 256;
        end
      end
    endcase
  endtask

  // Called just after a falling edge: drive inputs, step the model, compare at the next falling edge.
  task automatic step(input string tag, input bit s, input bit f, input logic [7:0] bt, input bit i);
    stall = s; flush = f; branch_target = bt; irq = i;
    model_edge(int'(s), int'(f), int'(bt), int'(i));
    @(negedge clk);
    check_all(tag);
    $display("step %s: s=%0b f=%0b bt=%02h irq=%0b -> addr=%02h ifid={%02h,%02h,%0b} ack=%0b ret=%02h",
             tag, s, f, bt, i, imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, irq_ack, irq_ret_pc);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hA1;
    mem[8'h11] = 8'hB2;
    mem[8'h40] = 8'h5C;
    mem[8'h80] = 8'hC7;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 8'h00; irq = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    chk("boot.cycle0_addr", int'(imem_addr), 8'h00);

    // Boot
    step("boot_edge", 0, 0, 8'h00, 0);
    chk("boot.first_pc", int'(imem_addr), 8'h10);
    step("fetch_a1", 0, 0, 8'h00, 0);
    chk("boot.instr_a1", int'(if_id_instr), 8'hA1);
    chk("boot.pcp1_11", int'(if_id_pc_plus1), 8'h11);

    // Stall for two cycles
    step("stall1", 1, 0, 8'h00, 0);
    chk("stall1.addr", int'(imem_addr), 8'h11);
    chk("stall1.instr", int'(if_id_instr), 8'hA1);
    step("stall2", 1, 0, 8'h00, 0);
    chk("stall2.addr", int'(imem_addr), 8'h11);
    step("fetch_b2", 0, 0, 8'h00, 0);
    chk("resume.instr_b2", int'(if_id_instr), 8'hB2);
    chk("resume.pcp1_12", int'(if_id_pc_plus1), 8'h12);

    // Interrupt at PC 0x12
    step("irq_take", 0, 0, 8'h00, 1);
    chk("irq.ret_pc", int'(irq_ret_pc), 8'h12);
    chk("irq.ack", int'(irq_ack), 1);
    chk("irq.vec_addr", int'(imem_addr), 8'h01);
    step("irq_vec", 0, 0, 8'h00, 0);
    chk("irq.ack_drop", int'(irq_ack), 0);
    step("handler", 0, 0, 8'h00, 0);
    chk("irq.handler_instr", int'(if_id_instr), 8'hC7);
    chk("irq.handler_valid", int'(if_id_valid), 1);

    // Flush beats stall
    step("flush_stall", 1, 1, 8'h40, 0);
    chk("flush.bubble", int'(if_id_valid), 0);
    step("target", 0, 0, 8'h00, 0);
    chk("flush.target_instr", int'(if_id_instr), 8'h5C);
    chk("flush.target_pcp1", int'(if_id_pc_plus1), 8'h41);

    // Interrupt with a concurrent older branch
    step("irq2_take", 0, 0, 8'h00, 1);
    step("irq2_vec_flush", 0, 1, 8'h30, 0);
    chk("irqflush.ret_pc", int'(irq_ret_pc), 8'h30);
    chk("irqflush.pc", int'(imem_addr), 8'h80);

    // PC wrap
    step("to_ff", 0, 1, 8'hFF, 0);
    step("wrap", 0, 0, 8'h00, 0);
    chk("wrap.pcp1", int'(if_id_pc_plus1), 8'h00);
    chk("wrap.addr", int'(imem_addr), 8'h00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           8'($urandom_range(0, 255)), ($urandom_range(0, 6) == 0));
    end

    // Asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    check_all("rst_release");
    step("reboot", 0, 0, 8'h00, 0);
    chk("reboot.pc", int'(imem_addr), 8'h10);
    for (int n = 0; n < 100; n++) begin
      step("rand2", ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           8'($urandom_range(0, 255)), ($urandom_range(0, 6) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 8-bit pipelined core. It owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register that the decode stage and the load-use stall logic read from. It supports boot-vector and interrupt-vector loading, stalls, and branch flush.

## Interface
- `DATA_WIDTH`, default 8: instruction and address width.
- `BOOT_VEC_ADDR`, default 8'h00: memory location holding the reset start PC.
- `IRQ_VEC_ADDR`, default 8'h01: memory location holding the interrupt handler PC.
- `NOP_INSTR`, default 8'h00: encoding inserted as a bubble.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: load-use stall from the hazard detector; 1 = hold PC and IF/ID.
- `flush` in 1: branch/jump taken, resolved in EX; 1 = redirect and discard IF/ID.
- `branch_target` in 8: new PC when `flush` = 1.
- `irq` in 1: level-sensitive interrupt request.
- `imem_addr` out 8: instruction-memory address (combinational from state/PC).
- `imem_data` in 8: instruction-memory read data, combinational in the same cycle.
- `if_id_instr` out 8: registered instruction to decode.
- `if_id_pc_plus1` out 8: registered PC+1 of that instruction.
- `if_id_valid` out 1: 0 = bubble.
- `irq_ack` out 1: one-cycle pulse when the interrupt vector is taken.
- `irq_ret_pc` out 8: registered return address of the last interrupt.

## Operation
- **State machine**
  - States: BOOT, RUN, IRQ_VEC.
  - Reset enters BOOT.
- **BOOT** (exactly one cycle)
  - `imem_addr` = `BOOT_VEC_ADDR`.
  - At the edge: PC <= `imem_data`, IF/ID <= bubble, state <= RUN.
  - `stall`, `flush` and `irq` are ignored.
- **RUN**
  - `imem_addr` = PC.
  - Priority per edge: `flush` > `stall` > `irq` > normal.
  - `flush`: PC <= `branch_target`; IF/ID <= bubble (instr = `NOP_INSTR`, valid = 0, pc_plus1 unchanged).
  - `stall` (no flush): PC and all IF/ID fields hold.
  - `irq` (no flush, no stall): `irq_ret_pc` <= PC; PC holds; IF/ID <= bubble; state <= IRQ_VEC.
  - Normal: IF/ID <= {`imem_data`, PC+1, valid = 1}; PC <= PC+1.
- **IRQ_VEC** (exactly one cycle)
  - `imem_addr` = `IRQ_VEC_ADDR`.
  - `irq_ack` = 1 (Moore output of this state).
  - At the edge: PC <= `imem_data`; IF/ID <= bubble; state <= RUN.
  - If `flush` = 1 in this cycle (a branch in EX that was older than the interrupt), `irq_ret_pc` <= `branch_target`; the PC still loads the vector.
  - `stall` is ignored in IRQ_VEC.
- **Arithmetic**
  - PC+1 is modulo 2^8: 8'hFF + 1 = 8'h00, with no flag.
- **Interrupt source**
  - The source deasserts `irq` after seeing `irq_ack`.
  - If `irq` is still high on return to RUN, it is taken again (no internal masking).

## Timing
- Reset values (asynchronous):
  - PC = 8'h00, state = BOOT.
  - `if_id_instr` = `NOP_INSTR`, `if_id_pc_plus1` = 8'h00, `if_id_valid` = 0.
  - `irq_ret_pc` = 8'h00, `irq_ack` = 0.
- Fetch latency: an instruction presented at `imem_addr` in cycle N appears on `if_id_*` after the edge ending cycle N.
- After reset release:
  - Cycle 0: BOOT.
  - Cycle 1: first fetch from the boot PC.
  - Cycle 2: first `if_id_valid` = 1.
- Branch penalty: one bubble from this stage. The target instruction is in IF/ID one cycle after the flush edge.
- Interrupt entry costs two bubbles (IRQ_VEC entry edge, then the vector-load edge). The handler's first instruction is valid two cycles after the edge at which `irq` was accepted.
- A stall held for k cycles keeps `if_id_*` and `imem_addr` constant for k cycles.
- `rst` asserted mid-operation returns immediately to the reset values; BOOT reruns after release.

## Test plan
- **Boot:** M[0]=8'h10, M[0x10]=8'hA1, M[0x11]=8'hB2; release `rst` → cycle 0 `imem_addr`=0x00; then IF/ID = {A1, 0x11, 1}, then {B2, 0x12, 1}.
- **Stall:** `stall`=1 for 2 cycles while IF/ID = {A1, 0x11} → IF/ID and `imem_addr`=0x11 hold for 2 cycles, then fetch resumes at 0x11.
- **Flush with stall:** `flush`=1, `stall`=1, `branch_target`=0x40 → next IF/ID valid=0; the following cycle IF/ID holds M[0x40] with pc_plus1 = 0x41.
- **Interrupt:** M[1]=8'h80, `irq` at PC=0x12 → `irq_ret_pc`=0x12; `irq_ack` high one cycle with `imem_addr`=0x01; first valid IF/ID holds M[0x80].
- **Interrupt with flush:** `flush`=1, `branch_target`=0x30 during IRQ_VEC → `irq_ret_pc`=0x30, PC=0x80.
- **Wrap and reset:** PC=0xFF normal fetch → pc_plus1=0x00, next `imem_addr`=0x00. Then `rst` pulsed mid-run → all outputs at their reset values and BOOT repeats.
